// File: rtl/div_tx_pkg.sv
// rtl/div_tx_pkg.sv - shared types, ASCII constants and hex helper for the divider result UART
package div_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_DASH = 8'h2D;

  // Uppercase hex digit: 0..9 -> '0'..'9', 10..15 -> 'A'..'F' ('A' - 10 = 0x37)
  function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/div_uart_byte_tx.sv
// rtl/div_uart_byte_tx.sv - 8N1 serializer for one byte with back-to-back reload
module div_uart_byte_tx
  import div_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t         state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              bit_end;

  assign bit_end = ena && (baud_cnt == BAUD_LAST);

  // Last enabled cycle of the stop bit; the parent may load the next byte in
  // this same cycle so frames run back-to-back with no idle gap.
  assign byte_done = bit_end && (state == STOP);

  // Frame sequencer: start bit, 8 data bits LSB first, stop bit; ena=0 freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      tx       <= 1'b1;
    end else if (ena) begin
      if (load) begin
        state    <= START;
        baud_cnt <= '0;
        bit_cnt  <= 3'd0;
        shreg    <= data;
        tx       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            tx <= 1'b1;
          end
          START: begin
            if (bit_end) begin
              baud_cnt <= '0;
              state    <= DATA;
              tx       <= shreg[0];
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          DATA: begin
            if (bit_end) begin
              baud_cnt <= '0;
              if (bit_cnt == 3'd7) begin
                state <= STOP;
                tx    <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {1'b0, shreg[7:1]};
                tx      <= shreg[1];
              end
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          STOP: begin
            if (bit_end) begin
              baud_cnt <= '0;
              state    <= IDLE;
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/div_result_uart_tx.sv
// rtl/div_result_uart_tx.sv - sends a latched divider result as "QR\n" over UART 8N1
module div_result_uart_tx
  import div_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] result_in,
  input  logic       dz_in,
  input  logic       start,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  logic       capture;
  logic       load;
  logic       byte_done;
  logic [1:0] byte_idx;
  logic [3:0] rem_q;
  logic       dz_q;
  logic [7:0] byte_data;

  assign capture = ena && !busy && start;
  assign load    = capture || (byte_done && (byte_idx != 2'd2));

  // Byte 0 is loaded on the capture edge itself, so it comes straight from the
  // live inputs; only the remainder and dz flag need holding for later bytes.
  always_comb begin
    byte_data = ASCII_LF;
    if (capture) begin
      byte_data = dz_in ? ASCII_DASH : nibble_to_hex(result_in[7:4]);
    end else if (byte_idx == 2'd0) begin
      byte_data = dz_q ? ASCII_DASH : nibble_to_hex(rem_q);
    end
  end

  // Capture, byte sequencing and busy/done generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_idx <= 2'd0;
      rem_q    <= 4'h0;
      dz_q     <= 1'b0;
    end else begin
      // done is always a single-cycle pulse, even if ena drops right after it
      done <= 1'b0;
      if (capture) begin
        rem_q    <= result_in[3:0];
        dz_q     <= dz_in;
        busy     <= 1'b1;
        byte_idx <= 2'd0;
      end else if (byte_done) begin
        if (byte_idx == 2'd2) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          byte_idx <= 2'd0;
        end else begin
          byte_idx <= byte_idx + 2'd1;
        end
      end
    end
  end

  div_uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .load      (load),
    .data      (byte_data),
    .tx        (tx),
    .byte_done (byte_done)
  );

endmodule

// File: tb/tb_div_result_uart_tx.sv
// tb/tb_div_result_uart_tx.sv - directed self-checking bench for div_result_uart_tx
module tb_div_result_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] result_in;
  logic       dz_in;
  logic       start;
  logic       tx;
  logic       busy;
  logic       done;

  int vectors = 0;
  int errors  = 0;

  logic tx_log   [0:255];
  logic busy_log [0:255];
  logic done_log [0:255];
  bit   ena_log  [0:255];
  int   e_log    [0:255];

  always #5 clk = ~clk;

  div_result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .result_in (result_in),
    .dz_in     (dz_in),
    .start     (start),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic fbit(input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input int idx);
    logic [7:0] b;
    int j, i;
    j = idx / 10;
    i = idx % 10;
    b = (j == 0) ? b0 : (j == 1) ? b1 : b2;
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction

  // Launch one message from a negedge, log cycles 1..L, then check against a model
  // that advances one bit position per enabled cycle.
  task automatic run_msg(input string tag, input logic [7:0] res, input logic dz,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input int stall_at, input bit hold);
    int         stall, len, e, mism_tx, mism_bd, done_at, c_pick;
    logic       exp_tx, exp_busy, exp_done;
    logic [7:0] eb;
    logic [9:0] frame;
    stall = (stall_at > 0) ? 7 : 0;
    len   = 122 + stall;
    result_in = res;
    dz_in     = dz;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    result_in = 8'($urandom);
    dz_in     = 1'($urandom);
    for (int c = 1; c <= len; c++) begin
      tx_log[c]   = tx;
      busy_log[c] = busy;
      done_log[c] = done;
      ena = !(stall > 0 && c >= stall_at && c < stall_at + stall);
      ena_log[c] = ena;
      @(negedge clk);
    end
    ena = 1'b1;

    e = 0; mism_tx = 0; mism_bd = 0; done_at = 0;
    for (int c = 1; c <= len; c++) begin
      e_log[c] = e;
      if (e < 30 * CPB)          exp_tx = fbit(b0, b1, b2, e / CPB);
      else if (hold && c == len) exp_tx = 1'b0;
      else                       exp_tx = 1'b1;
      exp_busy = (e < 30 * CPB) || (hold && c == len);
      exp_done = (c == 30 * CPB + 1 + stall);
      if (tx_log[c] !== exp_tx) mism_tx++;
      if (busy_log[c] !== exp_busy || done_log[c] !== exp_done) mism_bd++;
      if (done_log[c] === 1'b1 && done_at == 0) done_at = c;
      e += int'(ena_log[c]);
    end
    chk({tag, " tx_wave_mismatch_cycles"}, 32'(mism_tx), 32'd0);
    chk({tag, " busy_done_mismatch_cycles"}, 32'(mism_bd), 32'd0);
    chk({tag, " done_cycle"}, 32'(done_at), 32'(30 * CPB + 1 + stall));

    for (int j = 0; j < 3; j++) begin
      eb = (j == 0) ? b0 : (j == 1) ? b1 : b2;
      for (int i = 0; i < 10; i++) begin
        c_pick = 0;
        for (int c = len; c >= 1; c--)
          if (e_log[c] == j * 10 * CPB + i * CPB + CPB / 2) c_pick = c;
        frame[i] = (c_pick > 0) ? tx_log[c_pick] : 1'bx;
      end
      chk($sformatf("%s frame%0d", tag, j), 32'(frame), 32'({1'b1, eb, 1'b0}));
    end
  endtask

  initial begin
    int dcount, done_k, bad_idle;
    rst_n     = 1'b0;
    ena       = 1'b1;
    start     = 1'b0;
    dz_in     = 1'b0;
    result_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle tx", 32'(tx), 32'd1);
    chk("idle busy", 32'(busy), 32'd0);

    run_msg("10/3", 8'h31, 1'b0, 8'h33, 8'h31, 8'h0A, 0, 1'b0);
    run_msg("15/5", 8'h30, 1'b0, 8'h33, 8'h30, 8'h0A, 0, 1'b0);
    run_msg("hexAF", 8'hAF, 1'b0, 8'h41, 8'h46, 8'h0A, 0, 1'b0);
    run_msg("divzero", 8'hFF, 1'b1, 8'h2D, 8'h2D, 8'h0A, 0, 1'b0);
    run_msg("stall", 8'h31, 1'b0, 8'h33, 8'h31, 8'h0A, 60, 1'b0);

    // start held: first message plus the start bit of the second right after done
    run_msg("held", 8'h31, 1'b0, 8'h33, 8'h31, 8'h0A, 0, 1'b1);
    start  = 1'b0;
    dcount = 0; done_k = -1; bad_idle = 0;
    for (int k = 0; k < 200; k++) begin
      if (done === 1'b1) begin
        dcount++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && (tx !== 1'b1 || busy !== 1'b0)) bad_idle++;
      @(negedge clk);
    end
    chk("held second done count", 32'(dcount), 32'd1);
    chk("held second done cycle", 32'(done_k), 32'd119);
    chk("held no extra traffic", 32'(bad_idle), 32'd0);

    // reset in the middle of byte 1 (tx is low at cycle 50 for 0x31 bit 1)
    result_in = 8'h31;
    dz_in     = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    chk("pre-reset tx", 32'(tx), 32'd0);
    chk("pre-reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset tx", 32'(tx), 32'd1);
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad_idle = 0;
    for (int k = 0; k < 40; k++) begin
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad_idle++;
      @(negedge clk);
    end
    chk("post-reset quiet", 32'(bad_idle), 32'd0);
    run_msg("after-reset", 8'h31, 1'b0, 8'h33, 8'h31, 8'h0A, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/div_result_uart_tx.md
# div_result_uart_tx

Downstream consumer of the 4-bit unsigned divider. It captures the divider's packed result byte (quotient in [7:4], remainder in [3:0]) on a start request and transmits it as ASCII over a UART 8N1 line. Each request sends three bytes: quotient hex digit, remainder hex digit, line feed. This lets the silicon's divide results be read by a host terminal on a single output pin.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clock cycles per UART bit; legal range 2..65535.

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  design enable; low freezes all state.
- result_in  in  8  divider output: [7:4] quotient, [3:0] remainder.
- dz_in  in  1  divide-by-zero flag from the divider stage (divisor == 0).
- start  in  1  level request; sampled each cycle.
- tx  out  1  UART serial line; idle high.
- busy  out  1  high while a 3-byte message is in flight.
- done  out  1  one-cycle pulse when a message completes.

## Operation
- Reset values: tx=1, busy=0, done=0, state=IDLE, all counters 0.
- Capture: on a clk edge with ena=1, busy=0, start=1:
  - latch result_in and dz_in;
  - busy=1 from the next cycle.
- start while busy=1 is ignored; there is no queueing.
- Byte sequence, byte index 0..2:
  - b0 = hex(quotient);
  - b1 = hex(remainder);
  - b2 = 0x0A.
- Hex mapping: n=0..9 -> 0x30+n; n=10..15 -> 0x41+(n-10). Uppercase only.
- Latched dz=1: b0 = b1 = 0x2D ('-'); b2 is unchanged.
- Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Frames are back-to-back with no idle gap.
- FSM states: IDLE -> START -> DATA -> STOP.
  - IDLE -> START on capture.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START if byte index < 2, else IDLE with done pulse.
- ena=0: baud counter, bit counter, byte index and state all hold; tx holds its current level; start is not sampled. Resuming continues exactly where it stopped.
- Reset asserted mid-message: tx=1, busy=0 and done=0 immediately (asynchronous). The message is abandoned and nothing resumes after reset.

## Timing
- Capture edge is cycle 0. tx drives the start bit from cycle 1.
- Each bit lasts exactly CLKS_PER_BIT enabled cycles.
- Full message = 30*CLKS_PER_BIT cycles, occupying cycles 1..30*CLKS_PER_BIT.
- At cycle 30*CLKS_PER_BIT+1: done=1 for one cycle, busy=0 in the same cycle, state=IDLE.
- A start high in the done cycle is accepted. The next start bit then begins one cycle later, so the minimum idle high between messages is 1 cycle.
- result_in and dz_in may change freely after capture; only the latched copies are transmitted.
- tx is registered: no combinational path from any input to tx.

## Structure
- Package div_tx_pkg:
  - FSM state enum (IDLE, START, DATA, STOP);
  - constants ASCII_LF=8'h0A and ASCII_DASH=8'h2D;
  - function nibble_to_hex(4-bit) -> 8-bit.
- Sub-module div_uart_byte_tx: serializes one byte.
  - Inputs: clk, rst_n, ena, load, data[7:0].
  - Outputs: tx, byte_done.
  - Owns the baud counter (width = clog2(CLKS_PER_BIT)) and the 3-bit bit counter.
- Top level: capture registers, byte index (2 bits), byte mux, busy/done generation.

## Test plan
All scenarios at CLKS_PER_BIT=4.
- 10/3: result_in=8'h31, dz_in=0, start pulse -> tx bytes 0x33, 0x31, 0x0A; done at cycle 121; busy high cycles 1..120.
- 15/5: result_in=8'h30 -> 0x33, 0x30, 0x0A. Also result_in=8'hAF -> 0x41, 0x46, 0x0A (checks the hex letter range).
- Divide by zero: dz_in=1, result_in=8'hFF -> 0x2D, 0x2D, 0x0A.
- start held high for the whole message -> exactly one message per done; the second message's start bit begins the cycle after done; no extra bytes.
- ena=0 for 7 cycles in the middle of the b1 data bits -> the affected bit lasts 4+7 cycles and the decoded bytes are unchanged; done at cycle 128.
- rst_n low at cycle 50 for 2 cycles -> tx=1 and busy=0 at once. After rst_n rises, no traffic until a new start; a fresh 10/3 request then transmits correctly.
